// File: rtl/tdm_demux_4_if.sv
// Bundle between a TDM word source and the tdm_demux_4 frame reassembler.
//   din/din_valid/frame_sync : serial word stream into the demux
//   Y0..Y3                    : last complete frame, channels A..D
//   sel                       : channel index expected on the next valid word
//   frame_valid               : one-cycle pulse after Y0..Y3 update
//   locked                    : demux is aligned to the frame (RUN)
//   sync_err                  : one-cycle pulse on a misplaced frame_sync
interface tdm_demux_4_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] Y1;
  logic [WIDTH-1:0] Y2;
  logic [WIDTH-1:0] Y3;
  logic [1:0]       sel;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  Y0, Y1, Y2, Y3, sel, frame_valid, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output Y0, Y1, Y2, Y3, sel, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_4.sv
// 1-to-4 time-division demultiplexer: collects channel words A..D from a
// serial stream into shadow registers and publishes a whole frame to
// Y0..Y3 at once, so a partial frame never reaches the outputs.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux_4_if slave (stream in, frame/status out)
module tdm_demux_4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux_4_if.slave  bus
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned N_CH  = 4;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic [N_CH-2:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0][WIDTH-1:0]   y_q, y_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         sync_err_q, sync_err_d;
  logic                         locked_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sel_q         <= '0;
      shadow_q      <= '0;
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= (state_d == RUN);
    end
  end

  // Next-state and frame assembly
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Unsynced words are dropped until the first channel-A marker
          if (bus.frame_sync) begin
            shadow_d[0] = bus.din;
            sel_d       = SEL_W'(1);
            state_d     = RUN;
          end
        end
        RUN: begin
          if (bus.frame_sync && (sel_q != '0)) begin
            // Misaligned marker: drop the partial frame, restart at channel A
            sync_err_d  = 1'b1;
            shadow_d[0] = bus.din;
            sel_d       = SEL_W'(1);
          end else if (sel_q == SEL_W'(N_CH - 1)) begin
            // Channel D completes the frame; publish all four together
            y_d[0]        = shadow_q[0];
            y_d[1]        = shadow_q[1];
            y_d[2]        = shadow_q[2];
            y_d[3]        = bus.din;
            frame_valid_d = 1'b1;
            sel_d         = '0;
          end else begin
            shadow_d[sel_q] = bus.din;
            sel_d           = SEL_W'(sel_q + SEL_W'(1));
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign bus.Y0          = y_q[0];
  assign bus.Y1          = y_q[1];
  assign bus.Y2          = y_q[2];
  assign bus.Y3          = y_q[3];
  assign bus.sel         = sel_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4: WIDTH=8 and WIDTH=1 instances.
module tb_tdm_demux_4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  tdm_demux_4_if #(.WIDTH(8)) bus8 ();
  tdm_demux_4_if #(.WIDTH(1)) bus1 ();

  tdm_demux_4 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  tdm_demux_4 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word at the falling edge, then sample #1 after the rising edge
  task automatic send(input logic [7:0] d, input logic v, input logic s);
    @(negedge clk);
    bus8.din        = d;
    bus8.din_valid  = v;
    bus8.frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic d, input logic s);
    @(negedge clk);
    bus1.din        = d;
    bus1.din_valid  = 1'b1;
    bus1.frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_y(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    check({tag, ".Y0"}, bus8.Y0, a);
    check({tag, ".Y1"}, bus8.Y1, b);
    check({tag, ".Y2"}, bus8.Y2, c);
    check({tag, ".Y3"}, bus8.Y3, d);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus8.din = '0; bus8.din_valid = 1'b0; bus8.frame_sync = 1'b0;
    bus1.din = '0; bus1.din_valid = 1'b0; bus1.frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_y("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    check("rst.sel", 8'(bus8.sel), 8'd0);
    check("rst.locked", 8'(bus8.locked), 8'd0);
    check("rst.fv", 8'(bus8.frame_valid), 8'd0);
    check("rst.serr", 8'(bus8.sync_err), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsynced words in HUNT are discarded
    send(8'h11, 1'b1, 1'b0); check("hunt.fv", 8'(bus8.frame_valid), 8'd0); check("hunt.sel", 8'(bus8.sel), 8'd0);
    send(8'h22, 1'b1, 1'b0); check("hunt.fv", 8'(bus8.frame_valid), 8'd0); check("hunt.sel", 8'(bus8.sel), 8'd0);
    send(8'h33, 1'b1, 1'b0); check("hunt.fv", 8'(bus8.frame_valid), 8'd0);
    send(8'h44, 1'b1, 1'b0); check("hunt.fv", 8'(bus8.frame_valid), 8'd0);
    check("hunt.locked", 8'(bus8.locked), 8'd0);
    check_y("hunt", 8'h00, 8'h00, 8'h00, 8'h00);

    // First synced frame
    send(8'hA1, 1'b1, 1'b1);
    check("f1.sel1", 8'(bus8.sel), 8'd1); check("f1.locked", 8'(bus8.locked), 8'd1);
    check("f1.fv1", 8'(bus8.frame_valid), 8'd0);
    send(8'hA2, 1'b1, 1'b0); check("f1.sel2", 8'(bus8.sel), 8'd2);
    send(8'hA3, 1'b1, 1'b0); check("f1.sel3", 8'(bus8.sel), 8'd3);
    check("f1.fv3", 8'(bus8.frame_valid), 8'd0);
    check_y("f1.partial", 8'h00, 8'h00, 8'h00, 8'h00);
    send(8'hA4, 1'b1, 1'b0); check("f1.sel0", 8'(bus8.sel), 8'd0);
    check("f1.fv4", 8'(bus8.frame_valid), 8'd1);
    check_y("f1", 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    send(8'hFF, 1'b0, 1'b0);
    check("f1.fv_off", 8'(bus8.frame_valid), 8'd0);
    check_y("f1.hold", 8'hA1, 8'hA2, 8'hA3, 8'hA4);

    // Free-running frame with idle gaps, no sync
    send(8'h05, 1'b1, 1'b0); check("f2.fv", 8'(bus8.frame_valid), 8'd0);
    send(8'hEE, 1'b0, 1'b1); check_y("f2.gap1", 8'hA1, 8'hA2, 8'hA3, 8'hA4); check("f2.gsel", 8'(bus8.sel), 8'd1);
    send(8'h06, 1'b1, 1'b0); check("f2.fv", 8'(bus8.frame_valid), 8'd0);
    send(8'hEE, 1'b0, 1'b0); check("f2.gfv", 8'(bus8.frame_valid), 8'd0);
    send(8'h07, 1'b1, 1'b0); check("f2.fv", 8'(bus8.frame_valid), 8'd0);
    send(8'hEE, 1'b0, 1'b0); check_y("f2.gap3", 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    send(8'h08, 1'b1, 1'b0); check("f2.fv", 8'(bus8.frame_valid), 8'd1);
    check_y("f2", 8'h05, 8'h06, 8'h07, 8'h08);
    send(8'h00, 1'b0, 1'b0); check("f2.fv_off", 8'(bus8.frame_valid), 8'd0);

    // Misplaced sync restarts the frame
    send(8'h10, 1'b1, 1'b0);
    send(8'h20, 1'b1, 1'b0); check("mis.serr0", 8'(bus8.sync_err), 8'd0);
    send(8'h30, 1'b1, 1'b1);
    check("mis.serr", 8'(bus8.sync_err), 8'd1); check("mis.sel", 8'(bus8.sel), 8'd1);
    check("mis.fv", 8'(bus8.frame_valid), 8'd0); check("mis.locked", 8'(bus8.locked), 8'd1);
    check_y("mis.hold", 8'h05, 8'h06, 8'h07, 8'h08);
    send(8'h40, 1'b1, 1'b0); check("mis.serr_off", 8'(bus8.sync_err), 8'd0);
    send(8'h50, 1'b1, 1'b0); check("mis.fv", 8'(bus8.frame_valid), 8'd0);
    send(8'h60, 1'b1, 1'b0); check("mis.fv_end", 8'(bus8.frame_valid), 8'd1);
    check_y("mis", 8'h30, 8'h40, 8'h50, 8'h60);

    // Sync at sel=0 is a normal channel A, then async reset mid-frame
    send(8'h91, 1'b1, 1'b1);
    check("ok_sync.serr", 8'(bus8.sync_err), 8'd0); check("ok_sync.sel", 8'(bus8.sel), 8'd1);
    send(8'h92, 1'b1, 1'b0);
    @(negedge clk);
    bus8.din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_y("arst", 8'h00, 8'h00, 8'h00, 8'h00);
    check("arst.locked", 8'(bus8.locked), 8'd0);
    check("arst.sel", 8'(bus8.sel), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h81, 1'b1, 1'b0);
    send(8'h82, 1'b1, 1'b0);
    send(8'h83, 1'b1, 1'b0);
    send(8'h84, 1'b1, 1'b0);
    check("post.locked", 8'(bus8.locked), 8'd0);
    check("post.fv", 8'(bus8.frame_valid), 8'd0);
    check_y("post", 8'h00, 8'h00, 8'h00, 8'h00);

    // WIDTH=1 instance
    send1(1'b1, 1'b1); check("w1.sel1", 8'(bus1.sel), 8'd1);
    send1(1'b0, 1'b0);
    send1(1'b1, 1'b0); check("w1.sel3", 8'(bus1.sel), 8'd3);
    send1(1'b1, 1'b0);
    check("w1.Y0", 8'(bus1.Y0), 8'd1);
    check("w1.Y1", 8'(bus1.Y1), 8'd0);
    check("w1.Y2", 8'(bus1.Y2), 8'd1);
    check("w1.Y3", 8'(bus1.Y3), 8'd1);
    check("w1.sel0", 8'(bus1.sel), 8'd0);
    check("w1.fv", 8'(bus1.frame_valid), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
